// File: rtl/ds_modulator_tx.sv
// Second-order error-feedback delta-sigma modulator: zero-order-holds PCM samples
// for OSR ticks and shapes the requantisation error with NTF = (1 - z^-1)^2.
module ds_modulator_tx #(
  parameter int IN_WIDTH     = 16,
  parameter int OUTPUT_WIDTH = 5,
  parameter int OSR          = 128,
  parameter int CLK_DIV      = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [IN_WIDTH-1:0]     in_data,
  output logic                           out_valid,
  output logic signed [OUTPUT_WIDTH-1:0] out_data,
  output logic                           frame_start,
  output logic                           underrun,
  input  logic                           underrun_clr
);

  localparam int SHIFT = IN_WIDTH - OUTPUT_WIDTH;
  localparam int EW    = SHIFT + 2;
  localparam int XW    = IN_WIDTH + 4;
  localparam int PW    = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic signed [XW-1:0]           C_HALF = XW'(2 ** (SHIFT - 1));
  localparam logic signed [XW-1:0]           C_YMAX = XW'(2 ** (OUTPUT_WIDTH - 1) - 1);
  localparam logic signed [XW-1:0]           C_YMIN = -C_YMAX;
  localparam logic signed [XW-1:0]           C_EMAX = XW'(2 ** (SHIFT + 1) - 1);
  localparam logic signed [XW-1:0]           C_EMIN = XW'(-(2 ** (SHIFT + 1)));
  localparam logic signed [OUTPUT_WIDTH-1:0] Y_MAX  = OUTPUT_WIDTH'(2 ** (OUTPUT_WIDTH - 1) - 1);
  localparam logic signed [OUTPUT_WIDTH-1:0] Y_MIN  = -Y_MAX;
  localparam logic signed [EW-1:0]           E_MAX  = EW'(2 ** (SHIFT + 1) - 1);
  localparam logic signed [EW-1:0]           E_MIN  = EW'(-(2 ** (SHIFT + 1)));

  logic signed [IN_WIDTH-1:0]     r_cur;
  logic signed [IN_WIDTH-1:0]     r_nbuf;
  logic                           r_full;
  logic signed [EW-1:0]           r_e1;
  logic signed [EW-1:0]           r_e2;
  logic [PW-1:0]                  r_phase;
  logic [DW-1:0]                  r_div;

  logic                           w_tick;
  logic                           w_last;
  logic                           w_accept;
  logic signed [XW-1:0]           w_v;
  logic signed [XW-1:0]           w_q;
  logic signed [XW-1:0]           w_d;
  logic signed [OUTPUT_WIDTH-1:0] w_y;
  logic signed [EW-1:0]           w_e;

  assign in_ready = !r_full;
  assign w_tick   = en && (r_div == DW'(CLK_DIV - 1));
  assign w_last   = (r_phase == PW'(OSR - 1));
  assign w_accept = in_valid && !r_full;

  // Quantiser and shaped error for the current tick, from registered state only.
  always_comb begin
    w_v = XW'(r_cur) + (XW'(r_e1) <<< 1) - XW'(r_e2);
    w_q = (w_v + C_HALF) >>> SHIFT;
    if (w_q > C_YMAX) begin
      w_y = Y_MAX;
    end else if (w_q < C_YMIN) begin
      w_y = Y_MIN;
    end else begin
      w_y = w_q[OUTPUT_WIDTH-1:0];
    end
    w_d = w_v - (XW'(w_y) <<< SHIFT);
    // Clamp only matters once the quantiser saturates near full scale.
    if (w_d > C_EMAX) begin
      w_e = E_MAX;
    end else if (w_d < C_EMIN) begin
      w_e = E_MIN;
    end else begin
      w_e = w_d[EW-1:0];
    end
  end

  // Tick divider, frame sequencing, sample buffer, loop state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur       <= '0;
      r_nbuf      <= '0;
      r_full      <= 1'b0;
      r_e1        <= '0;
      r_e2        <= '0;
      r_phase     <= '0;
      r_div       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (en) begin
        r_div <= (r_div == DW'(CLK_DIV - 1)) ? DW'(0) : r_div + DW'(1);
      end

      out_valid   <= w_tick;
      frame_start <= w_tick && (r_phase == PW'(0));

      if (w_tick) begin
        out_data <= w_y;
        r_e2     <= r_e1;
        r_e1     <= w_e;
        r_phase  <= w_last ? PW'(0) : r_phase + PW'(1);
      end

      // The boundary sees the buffer as it was before any same-cycle transfer.
      if (w_tick && w_last && r_full) begin
        r_cur <= r_nbuf;
      end

      if (w_accept) begin
        r_nbuf <= in_data;
        r_full <= 1'b1;
      end else if (w_tick && w_last && r_full) begin
        r_full <= 1'b0;
      end

      if (w_tick && w_last && !r_full) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ds_modulator_tx.sv
// Bench for ds_modulator_tx: instance A (CLK_DIV=1) against a tick-level arithmetic
// model, instance B (CLK_DIV=4) against frame-level expectations.
module tb_ds_modulator_tx;

  localparam int OSR = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              a_rst, a_en, a_vld, a_clr, a_rdy, a_ov, a_fs, a_ur;
  logic signed [15:0] a_data;
  logic signed [4:0]  a_od;
  logic              b_rst, b_en, b_vld, b_clr, b_rdy, b_ov, b_fs, b_ur;
  logic signed [15:0] b_data;
  logic signed [4:0]  b_od;
  logic [8:0]        got_a;

  assign got_a = {a_ov, a_fs, a_ur, a_rdy, a_od};

  ds_modulator_tx #(.IN_WIDTH(16), .OUTPUT_WIDTH(5), .OSR(OSR), .CLK_DIV(1)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .in_valid(a_vld), .in_ready(a_rdy),
    .in_data(a_data), .out_valid(a_ov), .out_data(a_od), .frame_start(a_fs),
    .underrun(a_ur), .underrun_clr(a_clr)
  );

  ds_modulator_tx #(.IN_WIDTH(16), .OUTPUT_WIDTH(5), .OSR(OSR), .CLK_DIV(4)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .in_valid(b_vld), .in_ready(b_rdy),
    .in_data(b_data), .out_valid(b_ov), .out_data(b_od), .frame_start(b_fs),
    .underrun(b_ur), .underrun_clr(b_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: held sample, two past errors, tick count, FIFO of pending samples.
  int m_cur = 0, m_e1 = 0, m_e2 = 0, m_ticks = 0, m_od = 0;
  bit m_ov = 0, m_fs = 0, m_ur = 0;
  int m_buf[$];

  function automatic int floor_div(int num, int den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  function automatic int clampi(int x, int lo, int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic logic [8:0] exp_a();
    return {m_ov, m_fs, m_ur, (m_buf.size() == 0), 5'(m_od)};
  endfunction

  task automatic model_step();
    int v, y, e;
    bit acc, bnd;
    if (a_rst) begin
      m_cur = 0; m_e1 = 0; m_e2 = 0; m_ticks = 0; m_od = 0;
      m_ov = 0; m_fs = 0; m_ur = 0;
      m_buf.delete();
      return;
    end
    acc = a_vld && (m_buf.size() == 0);
    bnd = 1'b0;
    if (a_en) begin
      v = m_cur + 2 * m_e1 - m_e2;
      y = clampi(floor_div(v + 1024, 2048), -15, 15);
      e = clampi(v - y * 2048, -4096, 4095);
      m_e2 = m_e1; m_e1 = e; m_od = y; m_ov = 1'b1;
      m_fs = (m_ticks % OSR == 0);
      bnd = (m_ticks % OSR == OSR - 1);
      m_ticks++;
    end else begin
      m_ov = 1'b0; m_fs = 1'b0;
    end
    if (a_clr) m_ur = 1'b0;
    if (bnd) begin
      if (m_buf.size() > 0) m_cur = m_buf.pop_front();
      else m_ur = 1'b1;
    end
    if (acc) m_buf.push_back(int'(a_data));
  endtask

  task automatic cyc_a();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_a();
    a_rst = 1'b1;
    cyc_a();
    a_rst = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; a_en = 1'b1; a_vld = 1'b1; a_data = 16'sd1000; a_clr = 1'b0;
    cyc_a();
    cyc_a();
    n_tests++;
    if (got_a !== 9'b0_0_0_1_00000) begin
      n_fail++;
      $display("FAIL reset got=%b exp=%b", got_a, 9'b0_0_0_1_00000);
    end
    a_vld = 1'b0;
    a_rst = 1'b0;
  endtask

  task automatic test_idle();
    int fs_cnt = 0;
    a_en = 1'b1; a_vld = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc_a();
      n_tests++;
      if (got_a !== exp_a()) begin
        n_fail++;
        $display("FAIL idle t=%0d got=%b exp=%b", i, got_a, exp_a());
      end
      if (a_fs) fs_cnt++;
    end
    n_tests++;
    if (fs_cnt !== 3) begin
      n_fail++;
      $display("FAIL idle_fs_count got=%0d exp=3", fs_cnt);
    end
    n_tests++;
    if (a_ur !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_underrun got=%b exp=1", a_ur);
    end
  endtask

  task automatic test_dc();
    bit after = 1'b0;
    do_reset_a();
    a_en = 1'b1; a_vld = 1'b1; a_data = 16'sd6144;
    cyc_a();
    a_vld = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc_a();
      n_tests++;
      if (got_a !== exp_a()) begin
        n_fail++;
        $display("FAIL dc t=%0d got=%b exp=%b", i, got_a, exp_a());
      end
      if (a_fs) after = 1'b1;
      if (after && a_ov) begin
        n_tests++;
        if (a_od !== 5'sd3) begin
          n_fail++;
          $display("FAIL dc_value t=%0d got=%0d exp=3", i, a_od);
        end
      end
    end
  endtask

  task automatic test_pattern();
    int pat[4] = '{1, 0, 0, 1};
    int k = 0;
    bit after = 1'b0;
    do_reset_a();
    a_en = 1'b1; a_vld = 1'b1; a_data = 16'sd1024;
    cyc_a();
    a_vld = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc_a();
      n_tests++;
      if (got_a !== exp_a()) begin
        n_fail++;
        $display("FAIL pattern t=%0d got=%b exp=%b", i, got_a, exp_a());
      end
      if (a_fs) after = 1'b1;
      if (after) begin
        n_tests++;
        if (a_od !== 5'(pat[k % 4])) begin
          n_fail++;
          $display("FAIL pattern_seq k=%0d got=%0d exp=%0d", k, a_od, pat[k % 4]);
        end
        k++;
      end
    end
  endtask

  task automatic test_extremes();
    int fr = 0, k = 0;
    do_reset_a();
    a_en = 1'b1; a_vld = 1'b1; a_data = 16'sd32767;
    cyc_a();
    a_vld = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        a_vld = 1'b1; a_data = -16'sd32768;
      end else begin
        a_vld = 1'b0;
      end
      cyc_a();
      n_tests++;
      if (got_a !== exp_a()) begin
        n_fail++;
        $display("FAIL extremes t=%0d got=%b exp=%b", i, got_a, exp_a());
      end
      if (a_fs) begin
        fr++; k = 0;
      end
      if (fr == 1) begin
        n_tests++;
        if (a_od !== 5'sd15) begin
          n_fail++;
          $display("FAIL extremes_pos k=%0d got=%0d exp=15", k, a_od);
        end
      end else if (fr == 2 && k >= 4) begin
        n_tests++;
        if (a_od !== -5'sd15) begin
          n_fail++;
          $display("FAIL extremes_neg k=%0d got=%0d exp=-15", k, a_od);
        end
      end
      k++;
    end
  endtask

  task automatic test_random();
    do_reset_a();
    for (int i = 0; i < 2000; i++) begin
      a_en   = ($urandom_range(0, 9) != 0);
      a_vld  = $urandom_range(0, 1);
      a_data = 16'($urandom);
      a_clr  = ($urandom_range(0, 19) == 0);
      a_rst  = ($urandom_range(0, 999) == 0);
      cyc_a();
      n_tests++;
      if (got_a !== exp_a()) begin
        n_fail++;
        $display("FAIL random t=%0d got=%b exp=%b", i, got_a, exp_a());
      end
    end
    a_rst = 1'b0; a_clr = 1'b0; a_vld = 1'b0; a_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    do_reset_a();
    a_en = 1'b1; a_vld = 1'b1; a_data = 16'sd2048;
    cyc_a();
    a_vld = 1'b0;
    for (int i = 0; i < 160; i++) cyc_a();
    a_vld = 1'b1; a_data = 16'sd4096;
    cyc_a();
    a_vld = 1'b0;
    for (int i = 0; i < 20; i++) cyc_a();
    a_rst = 1'b1; a_vld = 1'b1; a_data = 16'sd777;
    cyc_a();
    n_tests++;
    if (got_a !== 9'b0_0_0_1_00000) begin
      n_fail++;
      $display("FAIL mid_reset got=%b exp=%b", got_a, 9'b0_0_0_1_00000);
    end
    a_rst = 1'b0; a_vld = 1'b0;
    for (int i = 0; i < 132; i++) begin
      cyc_a();
      n_tests++;
      if (got_a !== exp_a() || a_od !== 5'sd0) begin
        n_fail++;
        $display("FAIL mid_reset_restart t=%0d got=%b exp=%b", i, got_a, exp_a());
      end
    end
    n_tests++;
    if (a_ur !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_underrun got=%b exp=1", a_ur);
    end
  endtask

  task automatic test_clkdiv();
    int idx = 0, strobes = 0, last_t = -1, rdy_cnt = 0, t = 0, exp_v;
    bit prev_rdy;
    b_rst = 1'b1; b_en = 1'b1; b_vld = 1'b1; b_data = 16'sd2048; b_clr = 1'b0;
    @(posedge clk); #1;
    b_rst = 1'b0;
    n_tests++;
    if ({b_rdy, b_ov, b_od} !== 7'b1_0_00000) begin
      n_fail++;
      $display("FAIL clkdiv_reset got=%b exp=%b", {b_rdy, b_ov, b_od}, 7'b1_0_00000);
    end
    prev_rdy = b_rdy;
    while (strobes < 6 * OSR && t < 4000) begin
      @(posedge clk); #1;
      t++;
      if (prev_rdy) begin
        idx++;
        b_data = 16'(2048 * (idx + 1));
      end
      if (b_rdy) rdy_cnt++;
      if (b_ov) begin
        if (last_t >= 0) begin
          n_tests++;
          if (t - last_t !== 4) begin
            n_fail++;
            $display("FAIL clkdiv_gap s=%0d got=%0d exp=4", strobes, t - last_t);
          end
        end
        n_tests++;
        if (b_fs !== (strobes % OSR == 0)) begin
          n_fail++;
          $display("FAIL clkdiv_fs s=%0d got=%b exp=%b", strobes, b_fs, (strobes % OSR == 0));
        end
        exp_v = strobes / OSR;
        n_tests++;
        if (b_od !== 5'(exp_v)) begin
          n_fail++;
          $display("FAIL clkdiv_data s=%0d got=%0d exp=%0d", strobes, b_od, exp_v);
        end
        last_t = t;
        strobes++;
      end
      prev_rdy = b_rdy;
    end
    n_tests++;
    if (strobes !== 6 * OSR) begin
      n_fail++;
      $display("FAIL clkdiv_budget got=%0d exp=%0d", strobes, 6 * OSR);
    end
    n_tests++;
    if (rdy_cnt !== 6) begin
      n_fail++;
      $display("FAIL clkdiv_ready got=%0d exp=6", rdy_cnt);
    end
    n_tests++;
    if (b_ur !== 1'b0) begin
      n_fail++;
      $display("FAIL clkdiv_underrun got=%b exp=0", b_ur);
    end
  endtask

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_vld = 1'b0; a_clr = 1'b0; a_data = 16'sd0;
    b_rst = 1'b1; b_en = 1'b0; b_vld = 1'b0; b_clr = 1'b0; b_data = 16'sd0;
    test_reset();
    test_idle();
    test_dc();
    test_pattern();
    test_extremes();
    test_random();
    test_mid_reset();
    test_clkdiv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ds_modulator_tx.md
Name: ds_modulator_tx

Overview:
Digital 2nd-order error-feedback delta-sigma modulator. It converts low-rate PCM samples into the 5-bit signed oversampled code stream that decimation_filter consumes on in_valid/in_data.
It is the source end of that interface. It provides loopback stimulus generation and a DAC-path front end.
Each accepted PCM sample is held for OSR output ticks (zero-order hold). The noise transfer function is NTF = (1 - z^-1)^2.

Parameters:
IN_WIDTH, 16, signed PCM input width
OUTPUT_WIDTH, 5, signed modulator code width (matches decimation_filter INPUT_WIDTH)
OSR, 128, output ticks per PCM sample (matches total decimation 16*2*2*2)
CLK_DIV, 1, clocks per output tick (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  tick enable; when low, all state is frozen and no output is produced
in_valid  input  1  PCM sample offered
in_ready  output  1  next-sample buffer empty; a transfer occurs when in_valid && in_ready
in_data  input  IN_WIDTH  signed PCM sample
out_valid  output  1  one-cycle strobe per output tick
out_data  output  OUTPUT_WIDTH  signed code, range -15..+15
frame_start  output  1  high with out_valid on the first tick of each held sample
underrun  output  1  sticky flag: a frame boundary occurred with the next-sample buffer empty
underrun_clr  input  1  clears underrun

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, frame_start=0, underrun=0, cur=0, nbuf empty (in_ready=1), e1=e2=0, phase=0, divcnt=0. Reset has priority over every other input, including mid-frame; the nbuf contents are discarded.
- Tick generation: divcnt counts 0..CLK_DIV-1 while en=1 and wraps to 0. tick = en && (divcnt == CLK_DIV-1). With CLK_DIV=1, every enabled cycle is a tick. When en=0, divcnt holds.
- Datapath on tick, computed combinationally from registered state:
  - Δ = 2^(IN_WIDTH-OUTPUT_WIDTH) = 2048.
  - v = cur + 2*e1 - e2, held in IN_WIDTH+2 signed bits with no overflow possible.
  - q = floor((v + Δ/2) / Δ), an arithmetic shift.
  - y = clamp(q, -15, +15).
  - e = clamp(v - y*Δ, -2Δ, 2Δ-1) = [-4096, 4095].
  - Registered updates: e2<=e1, e1<=e, out_data<=y.
- Latency: out_valid=1 for exactly one clock, the cycle after the tick. out_data holds its value between ticks. frame_start = (phase==0 at the tick), registered alongside out_valid.
- Frame sequencing: phase increments on each tick and wraps OSR-1 -> 0. On the tick where phase==OSR-1:
  - if nbuf is full: cur<=nbuf, nbuf becomes empty.
  - else: cur holds and underrun<=1.
- Input handshake: in_ready = !nbuf_full, combinational from a register. When in_valid && in_ready, nbuf<=in_data and nbuf becomes full.
  - There is no bypass. If a frame boundary and a transfer occur in the same cycle, the boundary sees the pre-transfer state: either it is an underrun, or it consumes the old nbuf while the new data lands in nbuf (full remains 1).
- underrun: set as described above. underrun_clr clears it. If set and clear occur in the same cycle, set wins.
- en=0: no ticks, out_valid=0, and phase, e1, e2, cur and divcnt are frozen. The handshake into nbuf still operates.

Test Plan:
1. Reset, en=1, no input -> out_valid every cycle and out_data=0 forever. underrun=1 after the first 128 ticks. frame_start every 128th strobe.
2. Preload in_data=6144, then wait one frame -> after the boundary, out_data=3 on every strobe with no toggling.
3. in_data=1024 loaded -> out_data repeats the 4-cycle pattern 1,0,0,1 starting at the frame boundary (mean 0.5 LSB).
4. in_data=32767 -> out_data=15 constant and never wraps negative. in_data=-32768 -> -15 constant. Internal error stays within [-4096, 4095].
5. CLK_DIV=4, in_valid held high with a sample sequence -> out_valid every 4th clock. in_ready drops after one accept and rises for one cycle per 512 clocks. No samples are lost, and underrun stays 0.
6. rst asserted mid-frame with nbuf full -> the next cycle shows all outputs at reset values, in_ready=1, and the output stream restarts at 0 as in scenario 1.
